// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants for the sync generator and the renderer.
package vga_timing_pkg;

  // Scan counter width; both totals must fit in it.
  localparam int CNT_W     = 10;
  localparam int CNT_LIMIT = 1 << CNT_W;

  // Sync polarity encodings.
  localparam logic SYNC_ACT_LOW  = 1'b0;
  localparam logic SYNC_ACT_HIGH = 1'b1;

  // 640x480 @ 60 Hz from a 100 MHz system clock.
  localparam int DEF_DIV    = 4;
  localparam int DEF_H_DISP = 640;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP   = 48;
  localparam int DEF_V_DISP = 480;
  localparam int DEF_V_FP   = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP   = 33;

  localparam int DEF_H_TOTAL = DEF_H_DISP + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_DISP + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // Inclusive window test used by the sync decode.
  function automatic logic in_win(input logic [CNT_W-1:0] v,
                                  input logic [CNT_W-1:0] lo,
                                  input logic [CNT_W-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// Free-running divide-by-DIV counter; o_adv is high on the last clk of each period.
module pixel_tick_div #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_adv
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == LAST);
  assign o_adv  = w_last;

  // Count 0..DIV-1 and wrap; with DIV=1 the counter sits at 0 and o_adv stays high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_cnt <= '0;
    else if (w_last) r_cnt <= '0;
    else             r_cnt <= r_cnt + CW'(1);
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA scan timing: pixel enable, h/v counters and registered sync/blanking strobes.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int   DIV      = DEF_DIV,
  parameter int   H_DISP   = DEF_H_DISP,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_DISP   = DEF_V_DISP,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic SYNC_POL = SYNC_ACT_LOW
) (
  input  logic             clk,
  input  logic             reset,
  output logic             p_tick,
  output logic             h_sync,
  output logic             v_sync,
  output logic             video_on,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             frame_start,
  output logic             line_end
);

  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

  // Reject timings the 10-bit counters cannot represent.
  if (H_TOTAL > CNT_LIMIT || V_TOTAL > CNT_LIMIT) begin : g_bad_total
    $error("vga_sync_gen: H_TOTAL/V_TOTAL must be <= 1024");
  end
  if (DIV < 1) begin : g_bad_div
    $error("vga_sync_gen: DIV must be >= 1");
  end

  localparam logic [CNT_W-1:0] HT_M1   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] VT_M1   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] HD      = CNT_W'(H_DISP);
  localparam logic [CNT_W-1:0] VD      = CNT_W'(V_DISP);
  localparam logic [CNT_W-1:0] HS_LO   = CNT_W'(H_DISP + H_FP);
  localparam logic [CNT_W-1:0] HS_HI   = CNT_W'(H_DISP + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_LO   = CNT_W'(V_DISP + V_FP);
  localparam logic [CNT_W-1:0] VS_HI   = CNT_W'(V_DISP + V_FP + V_SYNC - 1);

  logic             w_adv;
  logic [CNT_W-1:0] w_x_nxt, w_y_nxt;
  logic             w_hwrap;

  logic             r_tick, r_hs, r_vs, r_vid, r_fs, r_le;
  logic [CNT_W-1:0] r_x, r_y;

  pixel_tick_div #(.DIV(DIV)) u_div (
    .clk   (clk),
    .rst_n (reset),
    .o_adv (w_adv)
  );

  // Next scan position; all registered outputs are decoded from it so they
  // line up with the coordinates on the same edge.
  always_comb begin
    w_hwrap = (r_x == HT_M1);
    w_x_nxt = w_hwrap ? '0 : r_x + CNT_W'(1);
    w_y_nxt = r_y;
    if (w_hwrap) w_y_nxt = (r_y == VT_M1) ? '0 : r_y + CNT_W'(1);
  end

  // Scan counters and output registers; reset parks at the last pixel so the
  // first tick lands on (0,0) and a whole frame follows.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tick <= 1'b0;
      r_x    <= HT_M1;
      r_y    <= VT_M1;
      r_hs   <= ~SYNC_POL;
      r_vs   <= ~SYNC_POL;
      r_vid  <= 1'b0;
      r_fs   <= 1'b0;
      r_le   <= 1'b0;
    end else if (w_adv) begin
      r_tick <= 1'b1;
      r_x    <= w_x_nxt;
      r_y    <= w_y_nxt;
      r_hs   <= in_win(w_x_nxt, HS_LO, HS_HI) ? SYNC_POL : ~SYNC_POL;
      r_vs   <= in_win(w_y_nxt, VS_LO, VS_HI) ? SYNC_POL : ~SYNC_POL;
      r_vid  <= (w_x_nxt < HD) && (w_y_nxt < VD);
      r_fs   <= (w_x_nxt == '0) && (w_y_nxt == '0);
      r_le   <= (w_x_nxt == HT_M1);
    end else begin
      r_tick <= 1'b0;
      r_fs   <= 1'b0;
      r_le   <= 1'b0;
    end
  end

  assign p_tick      = r_tick;
  assign h_sync      = r_hs;
  assign v_sync      = r_vs;
  assign video_on    = r_vid;
  assign pixel_x     = r_x;
  assign pixel_y     = r_y;
  assign frame_start = r_fs;
  assign line_end    = r_le;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench: default-timing instance (A) and a tiny DIV=1, active-high instance (B).
module tb_vga_sync_gen;

  logic clk;
  logic rst_a, rst_b;
  int   n_tests, n_fail;
  int   na, nb;
  logic [25:0] sb_q[$];

  logic       a_tick, a_hs, a_vs, a_vid, a_fs, a_le;
  logic [9:0] a_x, a_y;
  logic       b_tick, b_hs, b_vs, b_vid, b_fs, b_le;
  logic [9:0] b_x, b_y;

  logic [25:0] a_out, b_out;
  assign a_out = {a_tick, a_hs, a_vs, a_vid, a_fs, a_le, a_x, a_y};
  assign b_out = {b_tick, b_hs, b_vs, b_vid, b_fs, b_le, b_x, b_y};

  vga_sync_gen dut_a (
    .clk(clk), .reset(rst_a), .p_tick(a_tick), .h_sync(a_hs), .v_sync(a_vs),
    .video_on(a_vid), .pixel_x(a_x), .pixel_y(a_y), .frame_start(a_fs), .line_end(a_le)
  );

  // H_TOTAL=15 (sync 10..12), V_TOTAL=8 (sync 5..6): a frame is 120 clks.
  vga_sync_gen #(
    .DIV(1), .H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_DISP(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1)
  ) dut_b (
    .clk(clk), .reset(rst_b), .p_tick(b_tick), .h_sync(b_hs), .v_sync(b_vs),
    .video_on(b_vid), .pixel_x(b_x), .pixel_y(b_y), .frame_start(b_fs), .line_end(b_le)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs n clk edges after reset release (n=0: reset state).
  function automatic logic [25:0] model(input int n, input int div,
      input int hd, input int hfp, input int hsw, input int hbp,
      input int vd, input int vfp, input int vsw, input int vbp, input logic pol);
    int ht, vt, k, lin, x, y;
    logic tk, h, v, vid, fs, le;
    ht = hd + hfp + hsw + hbp;
    vt = vd + vfp + vsw + vbp;
    k  = n / div;
    tk = (n > 0) && (n % div == 0);
    if (k == 0) begin
      x = ht - 1; y = vt - 1;
    end else begin
      lin = (k - 1) % (ht * vt);
      x = lin % ht; y = lin / ht;
    end
    h   = (x >= hd + hfp && x < hd + hfp + hsw) ? pol : ~pol;
    v   = (y >= vd + vfp && y < vd + vfp + vsw) ? pol : ~pol;
    vid = (k > 0) && (x < hd) && (y < vd);
    fs  = tk && (x == 0) && (y == 0);
    le  = tk && (x == ht - 1);
    return {tk, h, v, vid, fs, le, 10'(x), 10'(y)};
  endfunction

  function automatic logic [25:0] ma(input int n);
    return model(n, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
  endfunction

  function automatic logic [25:0] mb(input int n);
    return model(n, 1, 8, 2, 3, 2, 4, 1, 2, 1, 1'b1);
  endfunction

  task automatic chk(input string tag, input logic [25:0] got, input logic [25:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got tick=%b hs=%b vs=%b vid=%b fs=%b le=%b x=%0d y=%0d, exp tick=%b hs=%b vs=%b vid=%b fs=%b le=%b x=%0d y=%0d",
               tag, got[25], got[24], got[23], got[22], got[21], got[20], got[19:10], got[9:0],
               exp[25], exp[24], exp[23], exp[22], exp[21], exp[20], exp[19:10], exp[9:0]);
    end
  endtask

  task automatic step_a(input string tag);
    sb_q.push_back(ma(na + 1));
    @(posedge clk); #1;
    na++;
    chk(tag, a_out, sb_q.pop_front());
  endtask

  task automatic step_b(input string tag);
    sb_q.push_back(mb(nb + 1));
    @(posedge clk); #1;
    nb++;
    chk(tag, b_out, sb_q.pop_front());
  endtask

  initial begin
    n_tests = 0; n_fail = 0; na = 0; nb = 0;
    rst_a = 1'b0; rst_b = 1'b0;

    // Reset state of both instances.
    @(posedge clk); #3;
    sb_q.push_back(ma(0)); chk("A_reset", a_out, sb_q.pop_front());
    sb_q.push_back(mb(0)); chk("B_reset", b_out, sb_q.pop_front());

    // A: first frame start, all of line 0, into line 1 up to pixel 300.
    rst_a = 1'b1;
    while (na < 4405) step_a("A_run");

    // A: async reset between ticks at (300,1), seen before the next edge.
    #2 rst_a = 1'b0;
    #1 sb_q.push_back(ma(0)); chk("A_async_rst", a_out, sb_q.pop_front());
    @(posedge clk); #1;
    sb_q.push_back(ma(0)); chk("A_rst_hold", a_out, sb_q.pop_front());
    #2 rst_a = 1'b1; na = 0;
    while (na < 3300) step_a("A_restart");
    rst_a = 1'b0;

    // B: DIV=1 active-high; several frames including the (14,7)->(0,0) wrap.
    @(posedge clk); #3;
    rst_b = 1'b1;
    while (nb < 300) step_b("B_run");

    // B: async reset mid-frame, then clean restart.
    #2 rst_b = 1'b0;
    #1 sb_q.push_back(mb(0)); chk("B_async_rst", b_out, sb_q.pop_front());
    @(posedge clk); #1;
    sb_q.push_back(mb(0)); chk("B_rst_hold", b_out, sb_q.pop_front());
    #2 rst_b = 1'b1; nb = 0;
    while (nb < 130) step_b("B_restart");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
